// File: rtl/p_core.sv
`default_nettype none
// ============================================================================
// Module   : p_core (package)
// Purpose  : Shared types and constants for the core front end.
// Revision : 1.0  initial release
// ============================================================================
package p_core;

  // Byte distance between consecutive instruction words.
  localparam int INSTR_BYTES = 4;

  // One buffered fetch result as seen by decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        fault;
  } s_fetch_entry;

  // Fetch control state.
  typedef enum logic [0:0] {
    FETCH_RUN     = 1'b0,
    FETCH_FAULTED = 1'b1
  } e_fetch_state;

endpackage
`default_nettype wire

// File: rtl/m_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : m_fetch_queue
// Purpose  : In-order instruction FIFO with a registered head copy, so the
//            entry presented to decode comes straight from flops and holds
//            its last value once the queue drains.
// Revision : 1.0  initial release
// ============================================================================
module m_fetch_queue
  import p_core::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  s_fetch_entry             push_entry,
  output logic [$clog2(DEPTH):0]   count,
  output s_fetch_entry             head,
  output logic                     valid
);

  localparam int PTR_W = $clog2(DEPTH);

  s_fetch_entry     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W:0]   remain;
  logic [PTR_W:0]   count_nxt;
  logic             do_pop;

  assign valid      = (count != '0);
  assign do_pop     = pop && valid;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
  // Entries left once this cycle's pop is taken, before the push lands.
  assign remain     = count - (PTR_W + 1)'(do_pop);
  assign count_nxt  = remain + (PTR_W + 1)'(push);

  // Storage write; a flush cycle never writes.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Head copy: an empty queue takes the pushed word directly, otherwise the
  // next stored entry; holds when the queue is about to be empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else if (!flush && (count_nxt != '0)) begin
      head <= (remain == '0) ? push_entry : mem[rd_ptr_nxt];
    end
  end

  // Upstream credit accounting must never let a push hit a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !flush) |-> (remain < (PTR_W + 1)'(DEPTH)));

endmodule
`default_nettype wire

// File: rtl/m_fetch.sv
`default_nettype none
// ============================================================================
// Module   : m_fetch
// Purpose  : Instruction fetch stage. Issues sequential word addresses to
//            instruction memory under a queue credit limit, buffers the
//            in-order responses and hands them to decode. Redirects flush
//            the queue and drop responses still in flight; an errored
//            response halts fetching until the next redirect.
// Revision : 1.0  initial release
// ============================================================================
module m_fetch
  import p_core::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  e_fetch_state     state;
  e_fetch_state     state_nxt;
  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      redirect_base;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] inflight_after_resp;
  logic [CNT_W-1:0] drop;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W:0]   credit_used;
  logic             req_fire;
  logic             keep_resp;
  logic             q_pop;
  logic             q_valid;
  s_fetch_entry     push_entry;
  s_fetch_entry     head;

  assign redirect_base       = redirect_pc & ~32'h3;
  assign req_fire            = imem_req_valid && imem_req_ready;
  // Responses in a redirect cycle, or owed to a flushed stream, are discarded.
  assign keep_resp           = imem_resp_valid && !redirect_valid && (drop == '0);
  assign q_pop               = q_valid && out_ready && !redirect_valid;
  assign inflight_after_resp = inflight - CNT_W'(imem_resp_valid);
  assign credit_used         = {1'b0, q_count} + {1'b0, inflight};
  assign push_entry          = '{pc: resp_pc, instruction: imem_resp_data,
                                 fault: imem_resp_error};

  assign imem_req_addr   = fetch_pc;
  assign out_valid       = q_valid;
  assign out_instruction = head.instruction;
  assign out_pc          = head.pc;
  assign out_fault       = head.fault;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH_RUN;
    else        state <= state_nxt;
  end

  // FSM next state: a redirect always restarts, a kept error halts fetching.
  always_comb begin
    state_nxt = state;
    if (redirect_valid)                 state_nxt = FETCH_RUN;
    else if (keep_resp && imem_resp_error) state_nxt = FETCH_FAULTED;
  end

  // FSM output: request only while running, not redirecting, and with room
  // reserved in the queue for every outstanding response.
  always_comb begin
    imem_req_valid = rst_n && (state == FETCH_RUN) && !redirect_valid &&
                     (credit_used < (CNT_W + 1)'(QUEUE_DEPTH));
  end

  // Fetch/response PCs, in-flight credit and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_base;
      resp_pc  <= redirect_base;
      inflight <= inflight_after_resp;
      drop     <= inflight_after_resp;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
      inflight <= inflight_after_resp + CNT_W'(req_fire);
      if (imem_resp_valid) begin
        if (drop != '0) drop    <= drop - CNT_W'(1);
        else            resp_pc <= resp_pc + 32'(INSTR_BYTES);
      end
    end
  end

  m_fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (keep_resp),
    .pop        (q_pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .count      (q_count),
    .head       (head),
    .valid      (q_valid)
  );

endmodule
`default_nettype wire
